gray_monitor: RTL
=================

Name: gray_monitor

Overview:
- Downstream consumer of the 3-bit Gray step counter. Samples its Gray code output on each enabled cycle and converts it to binary.
- Tracks wrap-arounds into a wide extended step count.
- Flags any sample that is not a legal Gray step: hold, or advance by exactly one.
- Gives the datapath a binary position, a lap count and a sticky fault indication for the upstream counter.

Parameters:
- CNT_W, 16, width of extended step count (Count); wraps modulo 2^CNT_W.
- ERR_W, 4, width of saturating error counter (ErrCnt).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- Valid  input  1  sample strobe; Gray is examined only when Valid=1 (driven by the same enable as the upstream counter).
- Gray  input  3  Gray code from upstream counter.
- Ovf  input  1  upstream Overflow flag; used only when OVF_CHECK_EN is defined.
- Resync  input  1  synchronous request to drop lock and re-acquire on the next sample.
- Bin  output  3  binary value of last accepted code.
- Count  output  CNT_W  extended position = Laps*8 + Bin, modulo 2^CNT_W.
- Locked  output  1  1 while in LOCKED state.
- Err  output  1  sticky error flag.
- ErrCnt  output  ERR_W  number of illegal samples, saturating at all-ones.

Behaviour:
- Reset (Reset=0, async):
  - State=UNLOCKED.
  - Bin=0, Count=0, Locked=0, Err=0, ErrCnt=0, internal prev code=000, internal lap counter=0.
- Conversion: b2=g2; b1=g2^g1; b0=b1^g0. The valid sequence is 000,001,011,010,110,111,101,100.
- Registered outputs: all outputs update on the Clk edge that samples Valid=1. Latency is 1 cycle from the sample to the output.
- States: UNLOCKED, LOCKED, FAULT.
- UNLOCKED, Valid=1:
  - Capture Gray into prev.
  - Bin=conv(Gray); Count={laps,Bin} with laps reset to 0.
  - Go to LOCKED.
- LOCKED, Valid=1, comparing new binary n against previous binary p:
  - n==p: hold. No change; not an error (upstream stalls are legal).
  - n==p+1, p<7: advance. Bin=n, Count+=1.
  - p==7, n==0: wrap. Bin=0, Count+=1 (carries into lap bits), laps+=1.
  - Anything else: illegal. Err=1, ErrCnt+=1 (saturating), go to FAULT. Bin/Count hold their last legal values; prev is updated to the new code.
- FAULT:
  - Valid samples are ignored, except that each sample differing from prev increments ErrCnt (saturating) and updates prev.
  - Locked=0. Stays in FAULT until Resync or Reset.
- Resync=1 (any state):
  - Next state=UNLOCKED; Locked=0.
  - Err and ErrCnt are retained; Err is cleared only by Reset.
  - Resync takes priority over a simultaneous Valid sample; that sample is discarded.
- Upstream synchronous reset mid-count (e.g. 110 -> 000) is an illegal step and faults, unless the system pulses Resync in the same cycle.
- Count wrap at 2^CNT_W-1 -> 0 is silent and is not an error.
- ErrCnt at all-ones stays all-ones.
- Valid=0: all state holds.

Optional Feature:
- Macro: GRAY_MON_OVF_CHECK_EN.
- Defined:
  - Ovf is checked on every LOCKED Valid sample.
  - A 0->1 transition of Ovf is legal only in the same sample as a wrap (100 -> 000). A rise on any other sample is treated as illegal: Err=1, ErrCnt+=1, go to FAULT.
  - Ovf staying at 1 after a legal rise is allowed.
- Not defined: Ovf is unused. No Ovf-related logic or state exists.

Test Plan:
- Reset=0 for 2 cycles, then release -> Bin=0, Count=0, Locked=0, Err=0, ErrCnt=0.
- Valid=1, Gray steps 000..100 (8 codes) then 000 -> Locked=1 after the first sample; Bin follows 0..7,0; Count=8 after the 000 sample.
- In LOCKED at 011, hold 011 for 3 valid samples, then 010 -> Count unchanged during the holds, then +1; Err=0.
- In LOCKED at 001, feed 110 -> next cycle Err=1, ErrCnt=1, Locked=0, Bin=1. Then feed 111, 101 -> ErrCnt=3. Then Resync=1 followed by 000 -> Locked=1, Count=0, Err still 1.
- Reset asserted asynchronously mid-count (between edges) -> outputs go to 0 immediately, with no clock edge needed. After release the first sample re-locks.
- With GRAY_MON_OVF_CHECK_EN defined: Ovf rises at the 100->000 sample -> no error. Ovf rises at a 010->110 sample -> Err=1, ErrCnt+=1.

Source files
------------

// File: rtl/gray_monitor.sv
// gray_monitor: tracks a 3-bit Gray step counter into a binary position, lap count and fault status.
// Optional Ovf rise checking is compiled in with GRAY_MON_OVF_CHECK_EN.
module gray_monitor #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       gray,
    input  logic             ovf,
    input  logic             resync,
    output logic [2:0]       bin,
    output logic [CNT_W-1:0] count,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;
    localparam logic [CNT_W-4:0] LAP_ONE = 1;
    state_t state;
    logic [2:0] prev, n, p;
    logic [CNT_W-4:0] laps;
    logic wrap, ok, bad_ovf;
    logic [ERR_W-1:0] err_inc;

    function automatic logic [2:0] g2b(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

`ifdef GRAY_MON_OVF_CHECK_EN
    logic ovf_prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_prev <= 1'b0;
        else if (valid) ovf_prev <= ovf;
    // An Ovf rise is only credible on the sample that wraps 7 -> 0
    assign bad_ovf = ovf && !ovf_prev && !wrap;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign bad_ovf = 1'b0;
`endif

    // p+1 is taken modulo 8, so the wrap step is also covered by it
    always_comb begin
        n = g2b(gray);
        p = g2b(prev);
        wrap = p == 3'd7 && n == 3'd0;
        ok = !bad_ovf && (n == p || n == p + 3'd1);
        err_inc = err_cnt + ERR_W'(err_cnt != '1);
    end

    assign count = {laps, bin};
    assign locked = state == LOCKED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNLOCKED;
            prev <= '0;
            bin <= '0;
            laps <= '0;
            err <= 1'b0;
            err_cnt <= '0;
        end else if (resync) begin
            state <= UNLOCKED;
        end else if (valid) begin
            prev <= gray;
            if (state == UNLOCKED) begin
                bin <= n;
                laps <= '0;
                state <= LOCKED;
            end else if (state == LOCKED && ok) begin
                bin <= n;
                if (wrap) laps <= laps + LAP_ONE;
            end else if (state == LOCKED || gray != prev) begin
                err <= 1'b1;
                err_cnt <= err_inc;
                state <= FAULT;
            end
        end
    end
endmodule
